// File: rtl/i2c_target_regfile.sv
// I2C target responder: decodes address, register pointer and data bytes from an
// oversampled SCL/SDA pair and maps them onto an 8-bit register port.
module i2c_target_regfile #(
   parameter logic [6:0] I2C_ADDRESS = 7'h48
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i2c_scl,
   inout  wire logic  i2c_sda,
   output logic [7:0] o_regAddr,
   output logic       o_regWriteEn,
   output logic [7:0] o_regWriteData,
   input  logic [7:0] i_regReadData,
   output logic       o_busy,
   output logic [3:0] o_state
);

   typedef enum logic [3:0] {
      s_IDLE      = 4'd0,
      s_ADDR      = 4'd1,
      s_ADDR_ACK  = 4'd2,
      s_REG       = 4'd3,
      s_REG_ACK   = 4'd4,
      s_WRITE     = 4'd5,
      s_WRITE_ACK = 4'd6,
      s_READ      = 4'd7,
      s_READ_ACK  = 4'd8,
      s_IGNORE    = 4'd9
   } state_t;

   state_t      state;
   logic [1:0]  scl_sync, sda_sync;
   logic        scl_hist, sda_hist;
   logic        scl_s, sda_s;
   logic        scl_rise, scl_fall, start_det, stop_det;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;
   logic [7:0]  rx_byte;
   logic        rw;
   logic        rd_ack;
   logic        sda_oe;

   assign i2c_sda = sda_oe ? 1'b0 : 1'bz;
   assign o_state = state;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_hist <= 1'b1;
         sda_hist <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], i2c_scl};
         sda_sync <= {sda_sync[0], i2c_sda};
         scl_hist <= scl_sync[1];
         sda_hist <= sda_sync[1];
      end
   end

   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];
   assign scl_rise  = scl_s & ~scl_hist;
   assign scl_fall  = ~scl_s & scl_hist;
   assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
   assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;
   assign rx_byte   = {shreg[6:0], sda_s};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state          <= s_IDLE;
         bit_cnt        <= '0;
         shreg          <= '0;
         rw             <= 1'b0;
         rd_ack         <= 1'b0;
         sda_oe         <= 1'b0;
         o_regAddr      <= '0;
         o_regWriteEn   <= 1'b0;
         o_regWriteData <= '0;
         o_busy         <= 1'b0;
      end else begin
         o_regWriteEn <= 1'b0;
         if (stop_det) begin
            state   <= s_IDLE;
            sda_oe  <= 1'b0;
            o_busy  <= 1'b0;
            bit_cnt <= '0;
         end else if (start_det) begin
            state   <= s_ADDR;
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
         end else begin
            case (state)
               s_IDLE, s_IGNORE: sda_oe <= 1'b0;

               s_ADDR: if (scl_rise) begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (rx_byte[7:1] == I2C_ADDRESS) begin
                        rw     <= rx_byte[0];
                        o_busy <= 1'b1;
                        state  <= s_ADDR_ACK;
                     end else begin
                        o_busy <= 1'b0;
                        state  <= s_IGNORE;
                     end
                  end
               end

               s_REG: if (scl_rise) begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     o_regAddr <= rx_byte;
                     state     <= s_REG_ACK;
                  end
               end

               s_WRITE: if (scl_rise) begin
                  shreg   <= rx_byte;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     o_regWriteData <= rx_byte;
                     o_regWriteEn   <= 1'b1;
                     state          <= s_WRITE_ACK;
                  end
               end

               // First SCL fall after the 8th bit starts the ACK, the next one ends it.
               s_ADDR_ACK, s_REG_ACK, s_WRITE_ACK: if (scl_fall) begin
                  if (!sda_oe) begin
                     sda_oe <= 1'b1;
                  end else begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= '0;
                     if (state == s_ADDR_ACK) begin
                        if (rw) begin
                           shreg  <= i_regReadData;
                           sda_oe <= ~i_regReadData[7];
                           state  <= s_READ;
                        end else begin
                           state <= s_REG;
                        end
                     end else if (state == s_REG_ACK) begin
                        state <= s_WRITE;
                     end else begin
                        o_regAddr <= o_regAddr + 8'd1;
                        state     <= s_WRITE;
                     end
                  end
               end

               s_READ: if (scl_fall) begin
                  if (bit_cnt == 3'd7) begin
                     sda_oe  <= 1'b0;
                     rd_ack  <= 1'b0;
                     bit_cnt <= '0;
                     state   <= s_READ_ACK;
                  end else begin
                     sda_oe  <= ~shreg[6];
                     shreg   <= {shreg[6:0], 1'b0};
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end

               s_READ_ACK: begin
                  if (scl_rise) begin
                     o_regAddr <= o_regAddr + 8'd1;
                     if (sda_s) begin
                        o_busy <= 1'b0;
                        state  <= s_IGNORE;
                     end else begin
                        rd_ack <= 1'b1;
                     end
                  end else if (scl_fall && rd_ack) begin
                     shreg   <= i_regReadData;
                     sda_oe  <= ~i_regReadData[7];
                     bit_cnt <= '0;
                     state   <= s_READ;
                  end
               end

               default: begin
                  sda_oe <= 1'b0;
                  state  <= s_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: a bit-banged controller plus a register
// model that returns (address ^ 8'hFF) on reads.
module tb_i2c_target_regfile;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl;
   logic       ctl_sda;
   wire        sda_line;
   logic [7:0] reg_addr, wr_data, rd_data;
   logic       wr_en, busy;
   logic [3:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] stb_addr[$];
   logic [7:0] stb_data[$];

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_IGNORE = 4'd9;

   pullup (sda_line);
   assign sda_line = ctl_sda ? 1'bz : 1'b0;
   assign rd_data  = reg_addr ^ 8'hFF;

   always #5 clk = ~clk;

   i2c_target_regfile #(.I2C_ADDRESS(7'h48)) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i2c_scl        (scl),
      .i2c_sda        (sda_line),
      .o_regAddr      (reg_addr),
      .o_regWriteEn   (wr_en),
      .o_regWriteData (wr_data),
      .i_regReadData  (rd_data),
      .o_busy         (busy),
      .o_state        (state)
   );

   always @(negedge clk) begin
      if (wr_en) begin
         stb_addr.push_back(reg_addr);
         stb_data.push_back(wr_data);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      clks(8); ctl_sda = 1'b0;
      clks(8); scl = 1'b0;
   endtask

   task automatic i2c_rstart();
      clks(8); ctl_sda = 1'b1;
      clks(8); scl = 1'b1;
      clks(8); ctl_sda = 1'b0;
      clks(8); scl = 1'b0;
   endtask

   task automatic i2c_stop();
      clks(8); ctl_sda = 1'b0;
      clks(8); scl = 1'b1;
      clks(8); ctl_sda = 1'b1;
      clks(8);
   endtask

   task automatic send_bit(input logic b);
      clks(8); ctl_sda = b;
      clks(8); scl = 1'b1;
      clks(8); scl = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      clks(4); ctl_sda = 1'b1;
      clks(4); scl = 1'b1;
      clks(4); ack = sda_line;
      clks(4); scl = 1'b0;
   endtask

   task automatic read_byte(input logic ack_bit, output logic [7:0] b);
      ctl_sda = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         clks(8); scl = 1'b1;
         clks(4); b[i] = sda_line;
         clks(4); scl = 1'b0;
      end
      clks(4); ctl_sda = ack_bit;
      clks(4); scl = 1'b1;
      clks(8); scl = 1'b0;
      clks(1); ctl_sda = 1'b1;
   endtask

   task automatic check_strobes(input string tag, input int n,
                                input logic [7:0] a0, input logic [7:0] d0,
                                input logic [7:0] a1, input logic [7:0] d1);
      check_eq({tag, "_count"}, stb_addr.size(), n);
      if (n >= 1 && stb_addr.size() >= 1) begin
         check_eq({tag, "_addr0"}, stb_addr[0], a0);
         check_eq({tag, "_data0"}, stb_data[0], d0);
      end
      if (n >= 2 && stb_addr.size() >= 2) begin
         check_eq({tag, "_addr1"}, stb_addr[1], a1);
         check_eq({tag, "_data1"}, stb_data[1], d1);
      end
   endtask

   initial begin
      logic       ack;
      logic [7:0] rb;

      rst = 1'b1; scl = 1'b1; ctl_sda = 1'b1;
      clks(5);
      rst = 1'b0;
      clks(2);
      check_eq("rst_addr",  reg_addr, 8'h00);
      check_eq("rst_wen",   wr_en,    1'b0);
      check_eq("rst_wdata", wr_data,  8'h00);
      check_eq("rst_busy",  busy,     1'b0);
      check_eq("rst_state", state,    ST_IDLE);
      check_eq("rst_sda",   sda_line, 1'b1);

      // Write 0x48/W, reg 0x10, data 0xA5, 0x3C
      stb_addr.delete(); stb_data.delete();
      i2c_start();
      write_byte(8'h90, ack); check_eq("w1_addr_ack", ack, 1'b0);
      check_eq("w1_busy", busy, 1'b1);
      write_byte(8'h10, ack); check_eq("w1_reg_ack", ack, 1'b0);
      write_byte(8'hA5, ack); check_eq("w1_d0_ack", ack, 1'b0);
      write_byte(8'h3C, ack); check_eq("w1_d1_ack", ack, 1'b0);
      i2c_stop();
      check_strobes("w1", 2, 8'h10, 8'hA5, 8'h11, 8'h3C);
      check_eq("w1_ptr",   reg_addr, 8'h12);
      check_eq("w1_idle",  state,    ST_IDLE);
      check_eq("w1_unbusy", busy,    1'b0);

      // Pointer 0x20, repeated START, read three bytes, NACK the last
      i2c_start();
      write_byte(8'h90, ack); check_eq("r_addr_ack", ack, 1'b0);
      write_byte(8'h20, ack); check_eq("r_reg_ack",  ack, 1'b0);
      i2c_rstart();
      write_byte(8'h91, ack); check_eq("r_raddr_ack", ack, 1'b0);
      read_byte(1'b0, rb); check_eq("r_byte0", rb, 8'hDF);
      read_byte(1'b0, rb); check_eq("r_byte1", rb, 8'hDE);
      read_byte(1'b1, rb); check_eq("r_byte2", rb, 8'hDD);
      check_eq("r_state", state,    ST_IGNORE);
      check_eq("r_busy",  busy,     1'b0);
      check_eq("r_ptr",   reg_addr, 8'h23);
      i2c_stop();
      check_eq("r_idle",  state,    ST_IDLE);

      // Wrong address 0x49: no ACK, no strobes, never busy
      stb_addr.delete(); stb_data.delete();
      i2c_start();
      write_byte(8'h92, ack); check_eq("na_ack", ack, 1'b1);
      check_eq("na_busy", busy, 1'b0);
      write_byte(8'h55, ack); check_eq("na_data_ack", ack, 1'b1);
      check_eq("na_state", state, ST_IGNORE);
      i2c_stop();
      check_strobes("na", 0, 8'h00, 8'h00, 8'h00, 8'h00);
      check_eq("na_ptr", reg_addr, 8'h23);
      check_eq("na_idle", state, ST_IDLE);

      // Pointer wrap 0xFF -> 0x00
      stb_addr.delete(); stb_data.delete();
      i2c_start();
      write_byte(8'h90, ack);
      write_byte(8'hFF, ack);
      write_byte(8'h11, ack); check_eq("wr_d0_ack", ack, 1'b0);
      write_byte(8'h22, ack); check_eq("wr_d1_ack", ack, 1'b0);
      i2c_stop();
      check_strobes("wrap", 2, 8'hFF, 8'h11, 8'h00, 8'h22);
      check_eq("wrap_ptr", reg_addr, 8'h01);

      // STOP after 4 data bits discards the partial byte
      stb_addr.delete(); stb_data.delete();
      i2c_start();
      write_byte(8'h90, ack);
      write_byte(8'h30, ack);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      i2c_stop();
      check_strobes("part", 0, 8'h00, 8'h00, 8'h00, 8'h00);
      check_eq("part_state", state,    ST_IDLE);
      check_eq("part_sda",   sda_line, 1'b1);
      check_eq("part_ptr",   reg_addr, 8'h30);
      i2c_start();
      write_byte(8'h90, ack);
      write_byte(8'h40, ack);
      write_byte(8'h77, ack); check_eq("part_next_ack", ack, 1'b0);
      i2c_stop();
      check_strobes("next", 1, 8'h40, 8'h77, 8'h00, 8'h00);

      // Reset while the target drives a '0' read bit (ptr 0x80 -> data 0x7F)
      i2c_start();
      write_byte(8'h90, ack);
      write_byte(8'h80, ack);
      i2c_rstart();
      write_byte(8'h91, ack); check_eq("rr_addr_ack", ack, 1'b0);
      clks(6);
      check_eq("rr_drive0", sda_line, 1'b0);
      rst = 1'b1;
      clks(1);
      check_eq("rr_sda",   sda_line, 1'b1);
      check_eq("rr_addr",  reg_addr, 8'h00);
      check_eq("rr_wdata", wr_data,  8'h00);
      check_eq("rr_wen",   wr_en,    1'b0);
      check_eq("rr_busy",  busy,     1'b0);
      check_eq("rr_state", state,    ST_IDLE);
      rst = 1'b0;
      clks(4); scl = 1'b1;
      clks(8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
